// File: rtl/shift_register_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter:
// FSM state encoding, default frame width, counter widths and the
// debug snapshot that exposes the FSM and its counters.
package shift_register_pkg;

  // Default frame length in bits.
  localparam int DEFAULT_DATA_WIDTH = 16;

  // The gap counter must hold up to 255 idle cycles.
  localparam int MAX_GAP_CYCLES = 255;
  localparam int GAP_CNT_W      = 8;

  // Bit counter width in the debug snapshot (enough for 32-bit frames).
  localparam int DBG_BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  // Debug view of the transmitter: FSM state plus both counters.
  typedef struct packed {
    tx_state_t                 state;
    logic [DBG_BIT_CNT_W-1:0]  bit_count;
    logic [GAP_CNT_W-1:0]      gap_count;
  } tx_debug_t;

  // Last counter value for an idle gap of the given length. A zero-length
  // gap never enters the GAP state, so its value does not matter.
  function automatic logic [GAP_CNT_W-1:0] gap_last_value(input int gap_cycles);
    int last;
    last = (gap_cycles > 0) ? gap_cycles - 1 : 0;
    return GAP_CNT_W'(last);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Up-counter shared by the bit counter and the gap counter. The count
// clears to zero on load, then advances by one per enabled falling edge
// and saturates at last_value, so it never exceeds the frame or gap length.
module tx_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] last_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // Terminal count is reached when the counter sits on its last value.
  assign terminal = (count == last_value);

  // Clear on load, otherwise step toward last_value and hold there.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parallel_in_serial_out_tx_16_bit.sv
// Parallel-in / serial-out transmitter. A word accepted on the parallel
// side is shifted out LSB first, one bit per falling edge of Clk_In, with
// frame start/done markers. An optional idle gap separates frames.
//
// Handshake: a word transfers on a falling edge of Clk_In where both
// Data_Valid_In and Data_Ready_Out are high. Data_Ready_Out depends only
// on internal state, never on Data_Valid_In. While Data_Ready_Out is low
// the parallel inputs are ignored and the word in flight is untouched.
module parallel_in_serial_out_tx_16_bit
  import shift_register_pkg::*;
#(
  parameter int   DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic                  Busy_Out,
  output tx_debug_t             Debug_Out
);

  localparam int                   CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = gap_last_value(GAP_CYCLES);
  localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);

  tx_state_t             state;
  tx_state_t             next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_count;
  logic                  bit_last;
  logic [GAP_CNT_W-1:0]  gap_count;
  logic                  gap_last;
  logic                  xfer;
  logic                  bit_load;
  logic                  bit_enable;
  logic                  gap_load;
  logic                  gap_enable;

  // A word moves into the shift register when both sides agree.
  assign xfer = Data_Valid_In && Data_Ready_Out;

  // Bit counter restarts with every accepted word and steps once per bit.
  assign bit_load   = xfer;
  assign bit_enable = (state == ST_SHIFT);

  // Gap counter restarts at the last bit so it is at zero on entering GAP.
  assign gap_load   = (state == ST_SHIFT) && bit_last;
  assign gap_enable = (state == ST_GAP);

  tx_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .clk        (Clk_In),
    .rst_n      (Reset_N_In),
    .load       (bit_load),
    .enable     (bit_enable),
    .last_value (BIT_LAST),
    .count      (bit_count),
    .terminal   (bit_last)
  );

  tx_bit_counter #(
    .WIDTH (GAP_CNT_W)
  ) u_gap_counter (
    .clk        (Clk_In),
    .rst_n      (Reset_N_In),
    .load       (gap_load),
    .enable     (gap_enable),
    .last_value (GAP_LAST),
    .count      (gap_count),
    .terminal   (gap_last)
  );

  // State register; reset aborts any frame immediately.
  always_ff @(negedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: a new word after the last bit chains with no bubble.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_last) begin
          if (xfer) begin
            next_state = ST_SHIFT;
          end else if (HAS_GAP) begin
            next_state = ST_GAP;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs: the line carries shift_reg[0] only while a frame is active.
  always_comb begin
    Data_Ready_Out   = 1'b0;
    Serial_Data_Out  = IDLE_LEVEL;
    Serial_Valid_Out = 1'b0;
    Frame_Start_Out  = 1'b0;
    Frame_Done_Out   = 1'b0;
    Busy_Out         = 1'b0;
    case (state)
      ST_IDLE: begin
        Data_Ready_Out = 1'b1;
      end
      ST_SHIFT: begin
        Data_Ready_Out   = bit_last && !HAS_GAP;
        Serial_Data_Out  = shift_reg[0];
        Serial_Valid_Out = 1'b1;
        Frame_Start_Out  = (bit_count == '0);
        Frame_Done_Out   = bit_last;
        Busy_Out         = 1'b1;
      end
      ST_GAP: begin
        Busy_Out = 1'b1;
      end
      default: begin
        Busy_Out = 1'b0;
      end
    endcase
  end

  // Shift register: load on transfer, otherwise shift right with idle fill.
  always_ff @(negedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      shift_reg <= '0;
    end else if (xfer) begin
      shift_reg <= Data_In;
    end else if (state == ST_SHIFT) begin
      shift_reg <= {IDLE_LEVEL, shift_reg[DATA_WIDTH-1:1]};
    end
  end

  // Debug snapshot of the FSM and both counters.
  assign Debug_Out = {state, DBG_BIT_CNT_W'(bit_count), gap_count};

endmodule

// File: tb/tb_parallel_in_serial_out_tx_16_bit.sv
// Bench for the serial transmitter. Three instances share one clock:
//   a: 16 bits, idle level 0, no gap
//   b: 16 bits, idle level 1, 3-cycle gap
//   c:  2 bits, idle level 1, 1-cycle gap
// A cycle-level frame model (word, bit index, gap cycles left) predicts
// every output; a bit queue tracks the serial stream of instance a.
module tb_parallel_in_serial_out_tx_16_bit;
  import shift_register_pkg::*;

  typedef struct packed {
    logic data;
    logic valid;
    logic start;
    logic done;
    logic busy;
    logic ready;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [15:0] din_a, din_b;
  logic [1:0]  din_c;
  logic        dv_a, dv_b, dv_c;
  logic        rdy_a, sd_a, sv_a, fs_a, fd_a, bz_a;
  logic        rdy_b, sd_b, sv_b, fs_b, fd_b, bz_b;
  logic        rdy_c, sd_c, sv_c, fs_c, fd_c, bz_c;
  tx_debug_t   dbg_a, dbg_b, dbg_c;

  parallel_in_serial_out_tx_16_bit #(
    .DATA_WIDTH (16), .IDLE_LEVEL (1'b0), .GAP_CYCLES (0)
  ) dut_a (
    .Clk_In (clk), .Reset_N_In (rst_n), .Data_In (din_a), .Data_Valid_In (dv_a),
    .Data_Ready_Out (rdy_a), .Serial_Data_Out (sd_a), .Serial_Valid_Out (sv_a),
    .Frame_Start_Out (fs_a), .Frame_Done_Out (fd_a), .Busy_Out (bz_a), .Debug_Out (dbg_a)
  );

  parallel_in_serial_out_tx_16_bit #(
    .DATA_WIDTH (16), .IDLE_LEVEL (1'b1), .GAP_CYCLES (3)
  ) dut_b (
    .Clk_In (clk), .Reset_N_In (rst_n), .Data_In (din_b), .Data_Valid_In (dv_b),
    .Data_Ready_Out (rdy_b), .Serial_Data_Out (sd_b), .Serial_Valid_Out (sv_b),
    .Frame_Start_Out (fs_b), .Frame_Done_Out (fd_b), .Busy_Out (bz_b), .Debug_Out (dbg_b)
  );

  parallel_in_serial_out_tx_16_bit #(
    .DATA_WIDTH (2), .IDLE_LEVEL (1'b1), .GAP_CYCLES (1)
  ) dut_c (
    .Clk_In (clk), .Reset_N_In (rst_n), .Data_In (din_c), .Data_Valid_In (dv_c),
    .Data_Ready_Out (rdy_c), .Serial_Data_Out (sd_c), .Serial_Valid_Out (sv_c),
    .Frame_Start_Out (fs_c), .Frame_Done_Out (fd_c), .Busy_Out (bz_c), .Debug_Out (dbg_c)
  );

  // ---------------- loopback receiver on instance a ----------------
  logic [15:0] sipo;
  logic        sipo_clr;
  always @(negedge clk) begin
    if (sipo_clr) sipo <= '0;
    else if (sv_a) sipo <= {sd_a, sipo[15:1]};
  end

  // ---------------- counters, model, scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  int   m_dw[3]   = '{16, 16, 2};
  int   m_gap[3]  = '{0, 3, 1};
  logic m_idle[3] = '{1'b0, 1'b1, 1'b1};

  bit          m_in_frame[3];
  logic [15:0] m_word[3];
  int          m_idx[3];
  int          m_gap_left[3];

  logic        drv_v[3];
  logic [15:0] drv_d[3];
  obs_t        obs[3];
  obs_t        exp_o[3];
  bit          acc[3];

  logic [0:0]  exp_q[$];

  logic a5c3_bits[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_in_frame[i] = 1'b0;
      m_word[i]     = '0;
      m_idx[i]      = 0;
      m_gap_left[i] = 0;
    end
  endfunction

  // Expected outputs for the current cycle, from frame/gap bookkeeping.
  function automatic obs_t model_out(int i);
    obs_t o;
    bit   last;
    last    = m_in_frame[i] && (m_idx[i] == m_dw[i] - 1);
    o.data  = m_in_frame[i] ? m_word[i][m_idx[i]] : m_idle[i];
    o.valid = m_in_frame[i];
    o.start = m_in_frame[i] && (m_idx[i] == 0);
    o.done  = last;
    o.busy  = m_in_frame[i] || (m_gap_left[i] > 0);
    o.ready = (!m_in_frame[i] && m_gap_left[i] == 0) || (last && m_gap[i] == 0);
    return o;
  endfunction

  // Advance the model across one falling edge.
  function automatic void model_step(int i);
    if (acc[i]) begin
      m_in_frame[i] = 1'b1;
      m_word[i]     = (i == 2) ? (drv_d[i] & 16'h0003) : drv_d[i];
      m_idx[i]      = 0;
    end else if (m_in_frame[i]) begin
      if (m_idx[i] == m_dw[i] - 1) begin
        m_in_frame[i] = 1'b0;
        m_gap_left[i] = m_gap[i];
      end else begin
        m_idx[i] = m_idx[i] + 1;
      end
    end else if (m_gap_left[i] > 0) begin
      m_gap_left[i] = m_gap_left[i] - 1;
    end
  endfunction

  function automatic void clear_drv();
    for (int i = 0; i < 3; i++) begin
      drv_v[i] = 1'b0;
      drv_d[i] = 16'($urandom);
    end
  endfunction

  // ---------------- driver ----------------
  // Sample all outputs at the rising edge (mid-cycle for this negedge
  // design), predict them, then present the next inputs.
  task automatic tick();
    @(posedge clk);
    obs[0] = {sd_a, sv_a, fs_a, fd_a, bz_a, rdy_a};
    obs[1] = {sd_b, sv_b, fs_b, fd_b, bz_b, rdy_b};
    obs[2] = {sd_c, sv_c, fs_c, fd_c, bz_c, rdy_c};
    for (int i = 0; i < 3; i++) exp_o[i] = model_out(i);
    dv_a = drv_v[0]; din_a = drv_d[0];
    dv_b = drv_v[1]; din_b = drv_d[1];
    dv_c = drv_v[2]; din_c = drv_d[2][1:0];
    for (int i = 0; i < 3; i++) begin
      acc[i] = drv_v[i] && exp_o[i].ready;
      model_step(i);
    end
    if (acc[0]) begin
      for (int k = 0; k < 16; k++) exp_q.push_back(drv_d[0][k]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_drv();
    dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({sd_a, sv_a, fs_a, fd_a, bz_a, rdy_a} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_a: got %b want 000001", {sd_a, sv_a, fs_a, fd_a, bz_a, rdy_a});
    end
    tests_run++;
    if ({sd_b, sv_b, fs_b, fd_b, bz_b, rdy_b} !== 6'b100001) begin
      tests_failed++;
      $display("FAIL reset_b: got %b want 100001", {sd_b, sv_b, fs_b, fd_b, bz_b, rdy_b});
    end
    tests_run++;
    if ({sd_c, sv_c, fs_c, fd_c, bz_c, rdy_c} !== 6'b100001) begin
      tests_failed++;
      $display("FAIL reset_c: got %b want 100001", {sd_c, sv_c, fs_c, fd_c, bz_c, rdy_c});
    end
    tests_run++;
    if ({dbg_a, dbg_b, dbg_c} !== 45'd0 || dbg_a.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_debug: got %h %h %h want 0", dbg_a, dbg_b, dbg_c);
    end
    @(posedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL reset_idle dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_a5c3();
    clear_drv();
    sipo_clr = 1'b1;
    drv_v[0] = 1'b1;
    drv_d[0] = 16'hA5C3;
    tick();
    sipo_clr = 1'b0;
    drv_v[0] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL a5c3_model dut%0d cyc%0d: got %b want %b", i, k, obs[i], exp_o[i]);
        end
      end
      if (k < 16) begin
        tests_run++;
        if ({obs[0].data, obs[0].valid, obs[0].start, obs[0].done} !==
            {a5c3_bits[k], 1'b1, (k == 0), (k == 15)}) begin
          tests_failed++;
          $display("FAIL a5c3_bit%0d: got d/v/s/e %b want %b", k,
                   {obs[0].data, obs[0].valid, obs[0].start, obs[0].done},
                   {a5c3_bits[k], 1'b1, (k == 0), (k == 15)});
        end
      end
    end
    tests_run++;
    if (sipo !== 16'hA5C3) begin
      tests_failed++;
      $display("FAIL a5c3_loopback: got %h want a5c3", sipo);
    end
  endtask

  task automatic test_back_to_back();
    int   vcnt, first_v, last_v;
    int   done_pos[$];
    logic [0:0] b;
    clear_drv();
    exp_q.delete();
    vcnt = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 34; c++) begin
      if (c == 0) begin
        drv_v[0] = 1'b1; drv_d[0] = 16'h0001;
      end else if (c <= 16) begin
        drv_v[0] = 1'b1; drv_d[0] = 16'h8000;
      end else begin
        drv_v[0] = 1'b0; drv_d[0] = 16'($urandom);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL b2b_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
      if (obs[0].valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
        last_v = c;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_stream cyc%0d: got valid bit %b want no bit", c, obs[0].data);
        end else begin
          b = exp_q.pop_front();
          if (obs[0].data !== b) begin
            tests_failed++;
            $display("FAIL b2b_stream cyc%0d: got %b want %b", c, obs[0].data, b);
          end
        end
      end
      if (obs[0].done) done_pos.push_back(c);
    end
    tests_run++;
    if (vcnt != 32 || last_v - first_v != 31) begin
      tests_failed++;
      $display("FAIL b2b_contiguous: got %0d valid over span %0d want 32 over 31",
               vcnt, last_v - first_v);
    end
    tests_run++;
    if (done_pos.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d want 2", done_pos.size());
    end else if (done_pos[1] - done_pos[0] != 16) begin
      tests_failed++;
      $display("FAIL b2b_done_spacing: got %0d want 16", done_pos[1] - done_pos[0]);
    end
  endtask

  task automatic test_gap();
    int nacc, gap_cnt, gap_bad;
    clear_drv();
    nacc = 0; gap_cnt = 0; gap_bad = 0;
    drv_v[1] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL gap_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
      if (nacc == 1 && !obs[1].valid && !obs[1].ready) begin
        gap_cnt++;
        if (obs[1].data !== 1'b1) gap_bad++;
      end
      if (acc[1]) begin
        nacc++;
        drv_d[1] = 16'($urandom);
        if (nacc == 2) drv_v[1] = 1'b0;
      end
    end
    tests_run++;
    if (nacc != 2 || gap_cnt != 3 || gap_bad != 0) begin
      tests_failed++;
      $display("FAIL gap_length: got frames %0d gap %0d non-idle %0d want 2 3 0",
               nacc, gap_cnt, gap_bad);
    end
  endtask

  task automatic test_width2();
    int nacc, starts, dones, overlaps;
    clear_drv();
    nacc = 0; starts = 0; dones = 0; overlaps = 0;
    for (int c = 0; c < 40; c++) begin
      drv_v[2] = (c < 30);
      drv_d[2] = 16'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL w2_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
      if (acc[2]) nacc++;
      if (obs[2].start) starts++;
      if (obs[2].done) dones++;
      if (obs[2].start && obs[2].done) overlaps++;
    end
    tests_run++;
    if (nacc < 2 || starts != nacc || dones != nacc || overlaps != 0) begin
      tests_failed++;
      $display("FAIL w2_markers: got frames %0d starts %0d dones %0d overlaps %0d",
               nacc, starts, dones, overlaps);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vcnt, dcnt;
    clear_drv();
    drv_v[0] = 1'b1;
    drv_d[0] = 16'hFFFF;
    tick();
    drv_v[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (obs[0] !== exp_o[0]) begin
        tests_failed++;
        $display("FAIL rst_mid_model bit%0d: got %b want %b", k, obs[0], exp_o[0]);
      end
    end
    // Mid-cycle of bit 7, far from any falling edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sd_a, sv_a, fs_a, fd_a, bz_a, rdy_a} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got %b want 000001", {sd_a, sv_a, fs_a, fd_a, bz_a, rdy_a});
    end
    @(posedge clk);
    rst_n = 1'b1;
    model_reset();
    vcnt = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL rst_mid_after dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
      if (c == 0) begin
        tests_run++;
        if (obs[0].ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL rst_mid_ready: got %b want 1", obs[0].ready);
        end
      end
      if (obs[0].valid) vcnt++;
      if (obs[0].done) dcnt++;
    end
    tests_run++;
    if (vcnt != 0 || dcnt != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_resend: got valid %0d done %0d want 0 0", vcnt, dcnt);
    end
  endtask

  task automatic test_idle_100();
    clear_drv();
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 3; i++) drv_d[i] = 16'($urandom);
      tick();
      tests_run++;
      if (obs[0].data !== 1'b0 || obs[0].busy !== 1'b0 ||
          obs[1].data !== 1'b1 || obs[1].busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle100 cyc%0d: got a=%b b=%b want data idle busy 0", c, obs[0], obs[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [0:0] b;
    clear_drv();
    exp_q.delete();
    for (int c = 0; c < 325; c++) begin
      for (int i = 0; i < 3; i++) begin
        drv_v[i] = (c < 300) && ($urandom_range(0, 3) != 0);
        drv_d[i] = 16'($urandom);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL rand_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_o[i]);
        end
      end
      if (obs[0].valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_stream cyc%0d: got valid bit %b want no bit", c, obs[0].data);
        end else begin
          b = exp_q.pop_front();
          if (obs[0].data !== b) begin
            tests_failed++;
            $display("FAIL rand_stream cyc%0d: got %b want %b", c, obs[0].data, b);
          end
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain: got %0d bits left want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sipo_clr = 1'b0;
    test_reset();
    test_a5c3();
    test_back_to_back();
    test_gap();
    test_width2();
    test_reset_mid_frame();
    test_idle_100();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
